// File: rtl/seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// seq_gen_pkg
// Shared definitions for the serial sequence generator:
//   - DIV_COUNT_DEF : default clk cycles between bit-clock edges
//   - PAT_W_DEF     : default maximum pattern length in bits
//   - seq_state_e   : transmit FSM states
// -----------------------------------------------------------------------------
package seq_gen_pkg;

   localparam int unsigned DIV_COUNT_DEF = 40_000_000;
   localparam int unsigned PAT_W_DEF     = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_SEND,
      ST_FINISH
   } seq_state_e;

endpackage : seq_gen_pkg

// File: rtl/seq_tick_div.sv
// -----------------------------------------------------------------------------
// seq_tick_div
// Free-running divider 0..DIV_COUNT-1 producing the slow bit clock.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset (divider and bit_clk to 0)
//   tick      : one-clk strobe in the cycle before each divider wrap
//   fall_tick : tick that will drive bit_clk from 1 to 0
//   bit_clk   : square wave, toggles on every tick (period 2*DIV_COUNT clks)
// -----------------------------------------------------------------------------
module seq_tick_div
   import seq_gen_pkg::*;
#(
   parameter int unsigned DIV_COUNT = DIV_COUNT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick,
   output logic fall_tick,
   output logic bit_clk
);

   localparam int unsigned CNT_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_COUNT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bit_clk_q, bit_clk_d;

   // Strobes are decoded from registered state, so they are glitch-free in
   // the clk domain and line up with the edge on which bit_clk toggles.
   assign tick      = (cnt_q == CNT_MAX);
   assign fall_tick = tick & bit_clk_q;
   assign bit_clk   = bit_clk_q;

   // NOTE: every output of a combinational block is assigned on every path,
   // otherwise synthesis infers a latch to hold the missing case.
   always_comb begin
      cnt_d     = tick ? '0 : cnt_q + 1'b1;
      bit_clk_d = bit_clk_q ^ tick;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         bit_clk_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bit_clk_q <= bit_clk_d;
      end
   end

endmodule : seq_tick_div

// File: rtl/serial_seq_gen.sv
// -----------------------------------------------------------------------------
// serial_seq_gen
// Shifts a captured pattern out MSB first, one bit per bit_clk period, with
// every bit change on a falling bit_clk edge so it is stable at each rise.
//   clk      : system clock, single domain
//   rst_n    : asynchronous active-low reset
//   start    : transmit request, accepted only while idle
//   abort    : synchronous cancel of a transfer in progress (no done pulse)
//   repeat_i : loop the captured pattern while high ("repeat" is a keyword)
//   pattern  : bits to send, MSB first, captured on start
//   len      : number of bits to send, 0 means PAT_W, captured on start
//   ser_out  : serial data
//   bit_clk  : pacing clock for the downstream detector
//   busy     : high from accepted start until return to idle
//   done     : one-clk pulse on normal completion
// -----------------------------------------------------------------------------
module serial_seq_gen
   import seq_gen_pkg::*;
#(
   parameter  int unsigned DIV_COUNT = DIV_COUNT_DEF,
   parameter  int unsigned PAT_W     = PAT_W_DEF,
   localparam int unsigned LEN_W     = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             repeat_i,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   output logic             ser_out,
   output logic             bit_clk,
   output logic             busy,
   output logic             done
);

   seq_state_e       state_q;
   logic [PAT_W-1:0] pat_q;     // captured pattern, reloaded on every repeat pass
   logic [PAT_W-1:0] shift_q;   // bits still to send, next one at the MSB
   logic [LEN_W-1:0] len_q;     // captured effective length
   logic [LEN_W-1:0] cnt_q;     // bits remaining after the one on ser_out
   logic             ser_q;
   logic             busy_q;
   logic             done_q;
   logic             div_tick;
   logic             fall_tick;
   logic [LEN_W-1:0] eff_len;

   seq_tick_div #(
      .DIV_COUNT (DIV_COUNT)
   ) u_tick_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (div_tick),
      .fall_tick (fall_tick),
      .bit_clk   (bit_clk)
   );

   assign eff_len = (len == '0) ? LEN_W'(PAT_W) : len;

   assign ser_out = ser_q;
   assign busy    = busy_q;
   assign done    = done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pat_q   <= '0;
         shift_q <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         ser_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // Abort wins over any tick or start arriving in the same cycle.
         if (abort && (state_q != ST_IDLE)) begin
            state_q <= ST_IDLE;
            ser_q   <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  ser_q <= 1'b0;
                  if (start) begin
                     pat_q   <= pattern;
                     len_q   <= eff_len;
                     busy_q  <= 1'b1;
                     state_q <= ST_ARM;
                  end
               end
               // Waiting for a falling edge keeps the first bit aligned with
               // a full bit period even if start came mid-period.
               ST_ARM: begin
                  if (fall_tick) begin
                     ser_q   <= pat_q[PAT_W-1];
                     shift_q <= pat_q << 1;
                     cnt_q   <= len_q - 1'b1;
                     state_q <= ST_SEND;
                  end
               end
               ST_SEND: begin
                  if (fall_tick) begin
                     if (cnt_q != '0) begin
                        ser_q   <= shift_q[PAT_W-1];
                        shift_q <= shift_q << 1;
                        cnt_q   <= cnt_q - 1'b1;
                     end else if (repeat_i) begin
                        // Last bit has had its full period: restart with no gap.
                        ser_q   <= pat_q[PAT_W-1];
                        shift_q <= pat_q << 1;
                        cnt_q   <= len_q - 1'b1;
                     end else begin
                        ser_q   <= 1'b0;
                        state_q <= ST_FINISH;
                     end
                  end
               end
               ST_FINISH: begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   // A falling-edge strobe is always one of the divider wrap strobes.
   a_fall_is_tick: assert property (@(posedge clk) disable iff (!rst_n)
      fall_tick |-> div_tick);

endmodule : serial_seq_gen
